// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one single-port RAM between SPI frames (rx_*/tx_*) and a host port (host_*), drives ram_*, flags dropped SPI commands on spi_ovf
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [DATA_SIZE-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0] ram_din,
  input  logic [DATA_SIZE-1:0] ram_dout,
  output logic                 spi_ovf
);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t state, next;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, p_addr, s_addr, rx_addr;
  logic [7:0] p_data, s_data;
  logic spi_pend, p_we, s_we, pri, own, is_data, clr, acc, spi_req, host_win, grant;
  always_comb begin
    rx_addr = rx_data[9] ? rd_addr : wr_addr;
    is_data = rx_valid & rx_data[8];
    clr = state == ISSUE & !own;
    acc = is_data & (!spi_pend | clr);
    spi_req = spi_pend | acc;
    grant = state == IDLE & (spi_req | host_req);
    host_win = host_req & (!spi_req | pri);
    s_we = spi_pend ? p_we : !rx_data[9];
    s_addr = spi_pend ? p_addr : rx_addr;
    s_data = spi_pend ? p_data : rx_data[7:0];
    next = state == IDLE ? (grant ? ISSUE : IDLE) : state == ISSUE ? (ram_we ? IDLE : RD_WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      p_addr <= '0;
      p_data <= '0;
      p_we <= 1'b0;
      spi_pend <= 1'b0;
      pri <= 1'b0;
      own <= 1'b0;
      spi_ovf <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_din <= '0;
      host_gnt <= 1'b0;
      host_rdata <= '0;
      host_rvalid <= 1'b0;
      tx_data <= '0;
      tx_valid <= 1'b0;
    end else begin
      if (is_data & !acc) spi_ovf <= 1'b1;
      if (rx_valid & !rx_data[8] & rx_data[9]) rd_addr <= ADDR_SIZE'(rx_data[7:0]);
      if (rx_valid & !rx_data[8] & !rx_data[9]) wr_addr <= ADDR_SIZE'(rx_data[7:0]);
      if (acc) begin
        spi_pend <= 1'b1;
        p_we <= !rx_data[9];
        p_addr <= rx_addr;
        p_data <= rx_data[7:0];
      end else if (clr) spi_pend <= 1'b0;
      ram_en <= grant;
      host_gnt <= grant & host_win;
      if (grant) begin
        own <= host_win;
        pri <= !host_win;
        ram_we <= host_win ? host_we : s_we;
        ram_addr <= host_win ? host_addr : s_addr;
        ram_din <= host_win ? host_wdata : DATA_SIZE'(s_data);
      end
      tx_valid <= state == RD_WAIT & !own;
      host_rvalid <= state == RD_WAIT & own;
      if (state == RD_WAIT & own) host_rdata <= ram_dout;
      if (state == RD_WAIT & !own) tx_data <= 8'(ram_dout);
    end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed and randomized checks of spi_ram_arbiter against a RAM-content and grant-order model
module tb_spi_ram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] rx_data;
  logic rx_valid, tx_valid, host_req, host_we, host_gnt, host_rvalid, ram_en, ram_we, spi_ovf;
  logic [7:0] tx_data, host_addr, host_wdata, host_rdata, ram_addr, ram_din, ram_dout;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  bit ram_init = 1'b0;
  int vec = 0, errs = 0;
  int gnt_cnt = 0, wr_cnt = 0, en_cnt = 0, txv_cnt = 0;

  spi_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
      ram_dout <= 8'h00;
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (host_gnt === 1'b1) gnt_cnt++;
    if (ram_en === 1'b1 && ram_we === 1'b1) wr_cnt++;
    if (ram_en === 1'b1) en_cnt++;
    if (tx_valid === 1'b1) txv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_send(input logic [1:0] c, input logic [7:0] p);
    rx_data = {c, p};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    host_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rx_data = {2'b01, 8'h33};
    rx_valid = 1'b1;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h01;
    host_wdata = 8'h02;
    repeat (3) tick();
    vec++;
    if ({ram_en, ram_we, ram_addr, ram_din, tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, spi_ovf} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: en=%0b we=%0b addr=%h din=%h tx=%h txv=%0b gnt=%0b rd=%h rv=%0b ovf=%0b expected all 0",
               ram_en, ram_we, ram_addr, ram_din, tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, spi_ovf);
    end
    rx_valid = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    vec++;
    if (ram_en !== 1'b0 || spi_ovf !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_reset: ram_en=%0b spi_ovf=%0b expected 0 0", ram_en, spi_ovf);
    end
  endtask

  task automatic test_spi_write();
    spi_send(2'b01, 8'h3C);
    vec++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h00 || ram_din !== 8'h3C) begin
      errs++;
      $display("FAIL spi_wr_reset_addr: en=%0b we=%0b addr=%h din=%h expected 1 1 00 3c", ram_en, ram_we, ram_addr, ram_din);
    end
    ref_mem[8'h00] = 8'h3C;
    tick();
    spi_send(2'b00, 8'h12);
    vec++;
    if (ram_en !== 1'b0) begin
      errs++;
      $display("FAIL addr_load_no_access: ram_en=%0b expected 0", ram_en);
    end
    spi_send(2'b01, 8'hA5);
    vec++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h12 || ram_din !== 8'hA5) begin
      errs++;
      $display("FAIL spi_write: en=%0b we=%0b addr=%h din=%h expected 1 1 12 a5", ram_en, ram_we, ram_addr, ram_din);
    end
    ref_mem[8'h12] = 8'hA5;
    tick();
    vec++;
    if (ram_en !== 1'b0) begin
      errs++;
      $display("FAIL spi_write_single_cycle: ram_en=%0b expected 0", ram_en);
    end
  endtask

  task automatic test_spi_read();
    spi_send(2'b10, 8'h12);
    spi_send(2'b11, 8'h00);
    vec++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h12) begin
      errs++;
      $display("FAIL spi_read_issue: en=%0b we=%0b addr=%h expected 1 0 12", ram_en, ram_we, ram_addr);
    end
    tick();
    vec++;
    if (tx_valid !== 1'b0 || ram_en !== 1'b0) begin
      errs++;
      $display("FAIL spi_read_wait: tx_valid=%0b ram_en=%0b expected 0 0", tx_valid, ram_en);
    end
    tick();
    vec++;
    if (tx_valid !== 1'b1 || tx_data !== ref_mem[8'h12]) begin
      errs++;
      $display("FAIL spi_read_data: tx_valid=%0b tx_data=%h expected 1 %h", tx_valid, tx_data, ref_mem[8'h12]);
    end
    tick();
    vec++;
    if (tx_valid !== 1'b0) begin
      errs++;
      $display("FAIL spi_read_pulse: tx_valid=%0b expected 0", tx_valid);
    end
  endtask

  task automatic test_host_rw();
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h00;
    host_wdata = 8'hFF;
    tick();
    vec++;
    if (host_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h00 || ram_din !== 8'hFF) begin
      errs++;
      $display("FAIL host_write: gnt=%0b en=%0b we=%0b addr=%h din=%h expected 1 1 1 00 ff", host_gnt, ram_en, ram_we, ram_addr, ram_din);
    end
    host_req = 1'b0;
    ref_mem[8'h00] = 8'hFF;
    tick();
    vec++;
    if (host_gnt !== 1'b0) begin
      errs++;
      $display("FAIL host_gnt_pulse: host_gnt=%0b expected 0", host_gnt);
    end
    host_req = 1'b1;
    host_we = 1'b0;
    tick();
    host_req = 1'b0;
    tick();
    vec++;
    if (host_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL host_read_early: host_rvalid=%0b expected 0", host_rvalid);
    end
    tick();
    vec++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'hFF) begin
      errs++;
      $display("FAIL host_read: rvalid=%0b rdata=%h expected 1 ff", host_rvalid, host_rdata);
    end
    tick();
  endtask

  task automatic test_tie();
    int g0;
    do_reset();
    g0 = gnt_cnt;
    spi_send(2'b10, 8'h30);
    rx_data = {2'b11, 8'h00};
    rx_valid = 1'b1;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 8'h40;
    tick();
    rx_valid = 1'b0;
    vec++;
    if (ram_en !== 1'b1 || host_gnt !== 1'b0 || ram_addr !== 8'h30) begin
      errs++;
      $display("FAIL tie_spi_first: en=%0b gnt=%0b addr=%h expected 1 0 30", ram_en, host_gnt, ram_addr);
    end
    tick();
    tick();
    vec++;
    if (tx_valid !== 1'b1 || tx_data !== ref_mem[8'h30] || host_gnt !== 1'b0) begin
      errs++;
      $display("FAIL tie_spi_data: txv=%0b tx=%h gnt=%0b expected 1 %h 0", tx_valid, tx_data, host_gnt, ref_mem[8'h30]);
    end
    tick();
    vec++;
    if (host_gnt !== 1'b1 || ram_addr !== 8'h40) begin
      errs++;
      $display("FAIL tie_host_next: gnt=%0b addr=%h expected 1 40", host_gnt, ram_addr);
    end
    host_req = 1'b0;
    tick();
    tick();
    vec++;
    if (host_rvalid !== 1'b1 || host_rdata !== ref_mem[8'h40]) begin
      errs++;
      $display("FAIL tie_host_data: rv=%0b rd=%h expected 1 %h", host_rvalid, host_rdata, ref_mem[8'h40]);
    end
    tick();
    tick();
    vec++;
    if (gnt_cnt - g0 != 1) begin
      errs++;
      $display("FAIL tie_gnt_once: grants=%0d expected 1", gnt_cnt - g0);
    end
  endtask

  task automatic test_back_to_back();
    spi_send(2'b00, 8'h70);
    spi_send(2'b01, 8'h01);
    vec++;
    if (ram_en !== 1'b1 || ram_addr !== 8'h70 || ram_din !== 8'h01) begin
      errs++;
      $display("FAIL b2b_first: en=%0b addr=%h din=%h expected 1 70 01", ram_en, ram_addr, ram_din);
    end
    spi_send(2'b01, 8'h02);
    vec++;
    if (ram_en !== 1'b0 || spi_ovf !== 1'b0) begin
      errs++;
      $display("FAIL b2b_accept: en=%0b ovf=%0b expected 0 0", ram_en, spi_ovf);
    end
    tick();
    vec++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h70 || ram_din !== 8'h02) begin
      errs++;
      $display("FAIL b2b_second: en=%0b we=%0b addr=%h din=%h expected 1 1 70 02", ram_en, ram_we, ram_addr, ram_din);
    end
    ref_mem[8'h70] = 8'h02;
    tick();
  endtask

  task automatic test_overflow();
    int w0;
    vec++;
    if (spi_ovf !== 1'b0) begin
      errs++;
      $display("FAIL ovf_initial: spi_ovf=%0b expected 0", spi_ovf);
    end
    spi_send(2'b00, 8'h60);
    w0 = wr_cnt;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 8'h50;
    tick();
    host_req = 1'b0;
    spi_send(2'b01, 8'h11);
    spi_send(2'b01, 8'h22);
    vec++;
    if (spi_ovf !== 1'b1 || host_rvalid !== 1'b1 || host_rdata !== ref_mem[8'h50]) begin
      errs++;
      $display("FAIL ovf_set: ovf=%0b rv=%0b rd=%h expected 1 1 %h", spi_ovf, host_rvalid, host_rdata, ref_mem[8'h50]);
    end
    tick();
    vec++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h60 || ram_din !== 8'h11) begin
      errs++;
      $display("FAIL ovf_kept_op: en=%0b we=%0b addr=%h din=%h expected 1 1 60 11", ram_en, ram_we, ram_addr, ram_din);
    end
    ref_mem[8'h60] = 8'h11;
    repeat (3) tick();
    vec++;
    if (wr_cnt - w0 != 1 || spi_ovf !== 1'b1) begin
      errs++;
      $display("FAIL ovf_one_write: writes=%0d ovf=%0b expected 1 1", wr_cnt - w0, spi_ovf);
    end
  endtask

  task automatic test_withdraw();
    int g0, e0;
    g0 = gnt_cnt;
    e0 = en_cnt;
    spi_send(2'b10, 8'h08);
    spi_send(2'b11, 8'h00);
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 8'h09;
    host_wdata = 8'h00;
    tick();
    host_req = 1'b0;
    repeat (3) tick();
    vec++;
    if (gnt_cnt != g0 || en_cnt - e0 != 1) begin
      errs++;
      $display("FAIL withdraw: grants=%0d accesses=%0d expected 0 1", gnt_cnt - g0, en_cnt - e0);
    end
  endtask

  task automatic test_reset_rd_wait();
    int t0;
    spi_send(2'b10, 8'h12);
    spi_send(2'b11, 8'h00);
    tick();
    t0 = txv_cnt;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({ram_en, ram_we, ram_addr, ram_din, tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, spi_ovf} !== '0) begin
      errs++;
      $display("FAIL reset_rd_wait: en=%0b we=%0b addr=%h din=%h tx=%h txv=%0b gnt=%0b rd=%h rv=%0b ovf=%0b expected all 0",
               ram_en, ram_we, ram_addr, ram_din, tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, spi_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    vec++;
    if (txv_cnt != t0 || ram_en !== 1'b0) begin
      errs++;
      $display("FAIL reset_abort: tx_valids=%0d ram_en=%0b expected 0 0", txv_cnt - t0, ram_en);
    end
    spi_send(2'b01, 8'h44);
    vec++;
    if (ram_en !== 1'b1 || ram_addr !== 8'h00 || ram_din !== 8'h44) begin
      errs++;
      $display("FAIL reset_idle_issue: en=%0b addr=%h din=%h expected 1 00 44", ram_en, ram_addr, ram_din);
    end
    ref_mem[8'h00] = 8'h44;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] a, d, sa, sd, ha, hdat;
    bit sw, hw, wh, hdn, sdn, lg_host;
    int kind, bad;
    do_reset();
    lg_host = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      a = 8'($urandom);
      d = 8'($urandom);
      if (kind == 0) begin
        spi_send(2'b00, a);
        spi_send(2'b01, d);
        vec++;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== a || ram_din !== d) begin
          errs++;
          $display("FAIL rnd_spi_wr: en=%0b we=%0b addr=%h din=%h expected 1 1 %h %h", ram_en, ram_we, ram_addr, ram_din, a, d);
        end
        ref_mem[a] = d;
        lg_host = 1'b0;
        tick();
      end else if (kind == 1) begin
        spi_send(2'b10, a);
        spi_send(2'b11, d);
        tick();
        tick();
        vec++;
        if (tx_valid !== 1'b1 || tx_data !== ref_mem[a]) begin
          errs++;
          $display("FAIL rnd_spi_rd: txv=%0b tx=%h expected 1 %h @%h", tx_valid, tx_data, ref_mem[a], a);
        end
        lg_host = 1'b0;
      end else if (kind == 2) begin
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = a;
        host_wdata = d;
        tick();
        vec++;
        if (host_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== a || ram_din !== d) begin
          errs++;
          $display("FAIL rnd_host_wr: gnt=%0b en=%0b we=%0b addr=%h din=%h expected 1 1 1 %h %h", host_gnt, ram_en, ram_we, ram_addr, ram_din, a, d);
        end
        host_req = 1'b0;
        ref_mem[a] = d;
        lg_host = 1'b1;
        tick();
      end else if (kind == 3) begin
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = a;
        tick();
        host_req = 1'b0;
        tick();
        tick();
        vec++;
        if (host_rvalid !== 1'b1 || host_rdata !== ref_mem[a]) begin
          errs++;
          $display("FAIL rnd_host_rd: rv=%0b rd=%h expected 1 %h @%h", host_rvalid, host_rdata, ref_mem[a], a);
        end
        lg_host = 1'b1;
      end else begin
        sw = 1'($urandom_range(0, 1));
        hw = 1'($urandom_range(0, 1));
        sa = {1'b0, a[6:0]};
        ha = {1'b1, d[6:0]};
        sd = 8'($urandom);
        hdat = 8'($urandom);
        spi_send(sw ? 2'b00 : 2'b10, sa);
        rx_data = {sw ? 2'b01 : 2'b11, sd};
        rx_valid = 1'b1;
        host_req = 1'b1;
        host_we = hw;
        host_addr = ha;
        host_wdata = hdat;
        wh = !lg_host;
        hdn = 1'b0;
        sdn = 1'b0;
        for (int k = 0; k < 12 && !(hdn && sdn); k++) begin
          tick();
          rx_valid = 1'b0;
          if (k == 0) begin
            vec++;
            if (host_gnt !== wh || ram_addr !== (wh ? ha : sa)) begin
              errs++;
              $display("FAIL rnd_tie_order: gnt=%0b addr=%h expected %0b %h", host_gnt, ram_addr, wh, wh ? ha : sa);
            end
          end
          if (host_gnt === 1'b1) begin
            host_req = 1'b0;
            vec++;
            if (ram_addr !== ha || ram_we !== hw || (hw && ram_din !== hdat)) begin
              errs++;
              $display("FAIL rnd_tie_host_issue: addr=%h we=%0b din=%h expected %h %0b %h", ram_addr, ram_we, ram_din, ha, hw, hdat);
            end
            if (hw) hdn = 1'b1;
          end
          if (host_rvalid === 1'b1) begin
            vec++;
            if (host_rdata !== ref_mem[ha]) begin
              errs++;
              $display("FAIL rnd_tie_host_rd: rd=%h expected %h", host_rdata, ref_mem[ha]);
            end
            hdn = 1'b1;
          end
          if (ram_en === 1'b1 && host_gnt !== 1'b1 && ram_we === 1'b1) begin
            vec++;
            if (ram_addr !== sa || ram_din !== sd) begin
              errs++;
              $display("FAIL rnd_tie_spi_wr: addr=%h din=%h expected %h %h", ram_addr, ram_din, sa, sd);
            end
            sdn = 1'b1;
          end
          if (tx_valid === 1'b1) begin
            vec++;
            if (tx_data !== ref_mem[sa]) begin
              errs++;
              $display("FAIL rnd_tie_spi_rd: tx=%h expected %h", tx_data, ref_mem[sa]);
            end
            sdn = 1'b1;
          end
        end
        vec++;
        if (!(hdn && sdn)) begin
          errs++;
          $display("FAIL rnd_tie_timeout: host_done=%0b spi_done=%0b expected 1 1", hdn, sdn);
        end
        host_req = 1'b0;
        if (sw) ref_mem[sa] = sd;
        if (hw) ref_mem[ha] = hdat;
        lg_host = !wh;
        tick();
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL rnd_ram_contents: %0d words differ, expected 0", bad);
    end
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_data = '0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_spi_write();
    test_spi_read();
    test_host_rw();
    test_tie();
    test_back_to_back();
    test_overflow();
    test_withdraw();
    test_reset_rd_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8, RAM address width; MEM_DEPTH = 2**ADDR_SIZE = 256.
REQ-002 Parameter DATA_SIZE, default 8, RAM word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
REQ-005 rx_data  input  10  SPI slave frame: [9:8] command, [7:0] payload.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 tx_data  output  8  read data returned to the SPI slave.
REQ-008 tx_valid  output  1  one-cycle strobe, tx_data valid.
REQ-009 host_req  input  1  local host access request, held until host_gnt.
REQ-010 host_we  input  1  1 = write, 0 = read; stable while host_req=1.
REQ-011 host_addr  input  ADDR_SIZE  host address; stable while host_req=1.
REQ-012 host_wdata  input  DATA_SIZE  host write data; stable while host_req=1.
REQ-013 host_gnt  output  1  one-cycle grant pulse.
REQ-014 host_rdata  output  DATA_SIZE  host read data.
REQ-015 host_rvalid  output  1  one-cycle strobe, host_rdata valid.
REQ-016 ram_en, ram_we  output  1 each  single-port RAM enable / write enable, registered.
REQ-017 ram_addr  output  ADDR_SIZE; ram_din  output  DATA_SIZE; registered.
REQ-018 ram_dout  input  DATA_SIZE  RAM read data, valid the cycle after ram_en=1, ram_we=0.
REQ-019 spi_ovf  output  1  sticky flag, SPI data command dropped.

Function
REQ-020 Commands: 00 = write address, 01 = write data, 10 = read address, 11 = read data (payload ignored).
REQ-021 Command 00 or 10 with rx_valid SHALL load wr_addr or rd_addr from payload at that edge, with no RAM access and regardless of FSM state.
REQ-022 Command 01 or 11 with rx_valid and spi_pend=0 SHALL set spi_pend and latch op, address (wr_addr or rd_addr as of that edge, before any same-edge update) and payload.
REQ-023 Command 01/11 with rx_valid while spi_pend=1 SHALL be dropped and set spi_ovf; the pending op is unchanged.
REQ-024 FSM states: IDLE, ISSUE, RD_WAIT.
REQ-025 IDLE: with spi_pend and/or host_req, select a winner, load ram_* registers, go to ISSUE; otherwise stay in IDLE.
REQ-026 Tie (both requesting): the requester without the last grant wins; the priority flag resets to favour SPI; every grant hands priority to the other requester.
REQ-027 ISSUE: ram_en=1 for exactly one cycle; host_gnt=1 in this cycle if the host won; spi_pend clears at the end of this cycle if SPI won.
REQ-028 ISSUE exit: write goes to IDLE; read goes to RD_WAIT.
REQ-029 RD_WAIT: capture ram_dout into tx_data (SPI) or host_rdata (host); pulse tx_valid or host_rvalid on the next cycle; go to IDLE.
REQ-030 Latency, idle request to ram_en: 1 cycle; read request to rvalid/tx_valid: 3 cycles.
REQ-031 Maximum one RAM access in flight; ram_en=0 in IDLE and RD_WAIT.
REQ-032 A new SPI data command may be accepted in the same cycle spi_pend clears (ISSUE end).
REQ-033 host_req deasserted before grant: the request is withdrawn and no access is made.
REQ-034 Address wrap: addresses are used modulo MEM_DEPTH; no auto-increment.

Reset
REQ-035 rst_n=0 SHALL immediately force: FSM=IDLE; spi_pend=0; priority flag = SPI; wr_addr=0; rd_addr=0.
REQ-036 rst_n=0 SHALL immediately force all outputs to 0: ram_en, ram_we, ram_addr, ram_din, tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, spi_ovf.
REQ-037 Reset mid-access aborts the access: no rvalid/tx_valid is produced and the pending op is discarded.
REQ-038 spi_ovf clears only on reset.

Verification
REQ-039 SPI write: rx 0x0_12 then 0x1_A5 -> ram_en=1, ram_we=1, ram_addr=0x12, ram_din=0xA5 one cycle after the second rx_valid.
REQ-040 SPI read: rx 0x2_12, then 0x3_00, RAM returns 0xA5 -> tx_data=0xA5 with tx_valid pulse 3 cycles after rx_valid.
REQ-041 Tie after reset: spi_pend and host_req (read 0x40) in the same cycle -> SPI is granted first, the host next; host_gnt is asserted exactly once.
REQ-042 Overflow: two 01 commands in consecutive cycles while the FSM is busy -> second is dropped, spi_ovf=1, only one RAM write occurs.
REQ-043 Reset in RD_WAIT -> all outputs are 0 immediately, no tx_valid follows, and FSM=IDLE.
REQ-044 Host write 0xFF@0x00 then host read 0x00 -> host_rdata=0xFF, with the host_rvalid pulse 3 cycles after grant-cycle request.
